// File: rtl/addsub_seq_if.sv
// Command, datapath and response bundle for addsub_seq; slave = sequencer side,
// master = issuer/datapath/consumer side.
interface addsub_seq_if #(
  parameter int N  = 4,
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic [N-1:0]  cmd_a;
  logic [N-1:0]  cmd_b;
  logic [N-1:0]  cmd_c;

  logic          dp_SM;
  logic          dp_SD;
  logic          dp_AS;
  logic [N-1:0]  dp_a;
  logic [N-1:0]  dp_b;
  logic [N-1:0]  dp_c;
  logic [N:0]    dp_sum;
  logic [N:0]    dp_sub;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [N:0]    rsp_result;
  logic          rsp_ovf;
  logic [CW-1:0] rsp_iters;

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_a, cmd_b, cmd_c,
    output cmd_ready,
    output dp_SM, dp_SD, dp_AS, dp_a, dp_b, dp_c,
    input  dp_sum, dp_sub,
    output rsp_valid, rsp_result, rsp_ovf, rsp_iters,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_a, cmd_b, cmd_c,
    input  cmd_ready,
    input  dp_SM, dp_SD, dp_AS, dp_a, dp_b, dp_c,
    output dp_sum, dp_sub,
    input  rsp_valid, rsp_result, rsp_ovf, rsp_iters,
    output rsp_ready
  );
endinterface

// File: rtl/addsub_seq.sv
// Sequencer around the add/sub datapath: accepts a command, iterates, returns result+overflow.
// Response k+1 cycles after accept; one command in flight; rsp held until rsp_ready. ADDSUB_SAT_EN = saturate instead of early exit.
module addsub_seq #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  addsub_seq_if.slave   bus,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic [N-1:0]  a_q, b_q, c_q;
  logic [1:0]    op_q;
  logic [CW-1:0] eff_cnt;
  logic [CW-1:0] iters;
  logic [N:0]    result;
  logic          ovf;

  logic [N:0]    r;
  logic          fits;
  logic [CW-1:0] iters_inc;
  logic          last;
`ifdef ADDSUB_SAT_EN
  logic [N:0]    r_sat;
`endif

  always_comb begin
    r         = op_q[0] ? bus.dp_sub : bus.dp_sum;
    fits      = (r[N] == r[N-1]);
    iters_inc = iters + CW'(1);
    last      = (iters_inc == eff_cnt);
`ifdef ADDSUB_SAT_EN
    r_sat     = r;
    if (!fits) begin
      r_sat = r[N] ? {2'b11, {(N-1){1'b0}}} : {2'b00, {(N-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      op_q    <= '0;
      eff_cnt <= '0;
      iters   <= '0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            a_q     <= bus.cmd_a;
            b_q     <= bus.cmd_b;
            c_q     <= bus.cmd_c;
            op_q    <= bus.cmd_op;
            eff_cnt <= (bus.cmd_cnt == '0) ? CW'(1) : bus.cmd_cnt;
            iters   <= '0;
            ovf     <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          iters <= iters_inc;
`ifdef ADDSUB_SAT_EN
          // Clamped value feeds back so later iterations start from the rail.
          result <= r_sat;
          a_q    <= r_sat[N-1:0];
          if (!fits) ovf <= 1'b1;
          if (last) state <= RESP;
`else
          result <= r;
          if (fits) begin
            a_q <= r[N-1:0];
            if (last) state <= RESP;
          end else begin
            ovf   <= 1'b1;
            state <= RESP;
          end
`endif
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign busy           = (state != IDLE);
  assign bus.dp_a       = a_q;
  assign bus.dp_b       = b_q;
  assign bus.dp_c       = c_q;
  assign bus.dp_AS      = op_q[0];
  assign bus.dp_SD      = op_q[0];
  assign bus.dp_SM      = op_q[1];
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_result = result;
  assign bus.rsp_ovf    = ovf;
  assign bus.rsp_iters  = iters;
endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed table, handshake/reset sequences, random commands vs integer model.
module tb_addsub_seq;
  localparam int N  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  addsub_seq_if #(.N(N), .CW(CW)) bus ();

  addsub_seq #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: signed add/sub of A with B or C, N+1-bit results.
  logic [N-1:0] dp_x;
  assign dp_x       = bus.dp_SM ? bus.dp_c : bus.dp_b;
  assign bus.dp_sum = {bus.dp_a[N-1], bus.dp_a} + {dp_x[N-1], dp_x};
  assign bus.dp_sub = {bus.dp_a[N-1], bus.dp_a} - {dp_x[N-1], dp_x};

  typedef struct {
    int       a, b, c;
    bit [1:0] op;
    int       cnt;
    int       res;
    bit       ovf;
    int       iters;
  } vec_t;

`ifdef ADDSUB_SAT_EN
  localparam int R2 = 7,  R3 = -8, R6 = -8,  I6 = 7;
`else
  localparam int R2 = 9,  R3 = -9, R6 = -10, I6 = 4;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] r5(input int v);
    logic [N:0] t;
    t = v[N:0];
    return {27'b0, t};
  endfunction

  // Reference: plain integer iteration following the command rules.
  task automatic model(input int a, b, c, input bit [1:0] op, input int cnt,
                       output int res, output bit ovf, output int iters);
    int n, acc, x, r;
    n = (cnt == 0) ? 1 : cnt;
    acc = a; res = 0; ovf = 0; iters = 0;
    for (int i = 0; i < n; i++) begin
      x = op[1] ? c : b;
      r = op[0] ? acc - x : acc + x;
      iters++;
      if (r > 7 || r < -8) begin
        ovf = 1;
`ifdef ADDSUB_SAT_EN
        r = (r > 7) ? 7 : -8;
`else
        res = r;
        break;
`endif
      end
      res = r;
      acc = r;
    end
  endtask

  task automatic drive_cmd(input int a, b, c, input bit [1:0] op, input int cnt);
    bus.cmd_a     = a[N-1:0];
    bus.cmd_b     = b[N-1:0];
    bus.cmd_c     = c[N-1:0];
    bus.cmd_op    = op;
    bus.cmd_cnt   = cnt[CW-1:0];
    bus.cmd_valid = 1'b1;
  endtask

  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (!bus.rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout actual=no_rsp required=rsp_valid");
    end
  endtask

  task automatic finish_rsp(input int exp_res);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("post_hs_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("post_hs_result_hold", {27'b0, bus.rsp_result}, r5(exp_res));
  endtask

  // Full transaction from an IDLE negedge; checks latency, selects, response and hold.
  task automatic run_txn(input int a, b, c, input bit [1:0] op, input int cnt,
                         input int exp_res, input bit exp_ovf, input int exp_iters,
                         input int hold);
    int cyc;
    chk("idle_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    drive_cmd(a, b, c, op, cnt);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("exec_busy", {31'b0, busy}, 32'd1);
    chk("dp_SM", {31'b0, bus.dp_SM}, {31'b0, op[1]});
    chk("dp_AS", {31'b0, bus.dp_AS}, {31'b0, op[0]});
    chk("dp_SD", {31'b0, bus.dp_SD}, {31'b0, op[0]});
    chk("dp_a", {28'b0, bus.dp_a}, {28'b0, a[N-1:0]});
    wait_rsp(1, cyc);
    chk("latency", cyc, exp_iters + 1);
    chk("result", {27'b0, bus.rsp_result}, r5(exp_res));
    chk("ovf", {31'b0, bus.rsp_ovf}, {31'b0, exp_ovf});
    chk("iters", {29'b0, bus.rsp_iters}, exp_iters);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("hold_result", {27'b0, bus.rsp_result}, r5(exp_res));
      chk("hold_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    end
    finish_rsp(exp_res);
  endtask

  vec_t vecs[6];

  initial begin
    int cyc, er, ei;
    bit eo;
    int ra, rb, rc, rcnt;
    bit [1:0] rop;

    vecs[0] = '{a: 3,  b: 2,  c: 0,  op: 2'b00, cnt: 1, res: 5,  ovf: 0, iters: 1};
    vecs[1] = '{a: 3,  b: 2,  c: 0,  op: 2'b00, cnt: 3, res: R2, ovf: 1, iters: 3};
    vecs[2] = '{a: -8, b: 0,  c: 1,  op: 2'b11, cnt: 1, res: R3, ovf: 1, iters: 1};
    vecs[3] = '{a: 5,  b: 0,  c: 1,  op: 2'b11, cnt: 0, res: 4,  ovf: 0, iters: 1};
    vecs[4] = '{a: -3, b: -4, c: 0,  op: 2'b01, cnt: 2, res: 5,  ovf: 0, iters: 2};
    vecs[5] = '{a: 2,  b: 0,  c: -3, op: 2'b10, cnt: 7, res: R6, ovf: 1, iters: I6};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_cnt = '0;
    bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_c = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_result", {27'b0, bus.rsp_result}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].op, vecs[i].cnt,
              vecs[i].res, vecs[i].ovf, vecs[i].iters, (i == 1) ? 2 : 0);

    // Backpressure with a second command waiting; it must wait for the handshake.
    drive_cmd(3, 2, 0, 2'b00, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    wait_rsp(1, cyc);
    drive_cmd(1, 1, 0, 2'b00, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_result", {27'b0, bus.rsp_result}, r5(5));
      chk("bp_iters", {29'b0, bus.rsp_iters}, 32'd1);
      chk("bp_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_busy", {31'b0, busy}, 32'd0);
    chk("bp_idle_valid", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_accepted", {31'b0, busy}, 32'd1);
    wait_rsp(1, cyc);
    chk("bp_second_latency", cyc, 2);
    chk("bp_second_result", {27'b0, bus.rsp_result}, r5(2));
    finish_rsp(2);

    // Reset in the middle of a long iteration.
    drive_cmd(1, 1, 0, 2'b00, 7);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_result", {27'b0, bus.rsp_result}, 32'd0);
    chk("mid_rst_ovf", {31'b0, bus.rsp_ovf}, 32'd0);
    chk("mid_rst_iters", {29'b0, bus.rsp_iters}, 32'd0);
    chk("mid_rst_dp_a", {28'b0, bus.dp_a}, 32'd0);
    chk("mid_rst_dp_b", {28'b0, bus.dp_b}, 32'd0);
    chk("mid_rst_sel", {29'b0, bus.dp_SM, bus.dp_SD, bus.dp_AS}, 32'd0);

    for (int t = 0; t < 60; t++) begin
      ra   = int'($urandom_range(0, 15)) - 8;
      rb   = int'($urandom_range(0, 15)) - 8;
      rc   = int'($urandom_range(0, 15)) - 8;
      rop  = 2'($urandom_range(0, 3));
      rcnt = int'($urandom_range(0, 7));
      model(ra, rb, rc, rop, rcnt, er, eo, ei);
      run_txn(ra, rb, rc, rop, rcnt, er, eo, ei, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Sequencing and capture stage wrapped around the combinational add/sub datapath (N-bit operands, N+1-bit Sum/Sub).
- Accepts an operation command through a valid/ready handshake and registers the operands.
- Drives the datapath select lines SM/SD/AS and the operands.
- Optionally iterates, feeding each result back as the next A operand.
- Captures the result, checks overflow and returns a registered response through a valid/ready handshake.

Parameters:
N, 4, operand width; the datapath result is N+1 bits.
CW, 3, width of the iteration count field.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  bit0 = subtract (AS), bit1 = use C instead of B (SM)
cmd_cnt  in  CW  iteration count; 0 is treated as 1
cmd_a  in  N  signed operand A
cmd_b  in  N  signed operand B
cmd_c  in  N  signed operand C
dp_SM  out  1  datapath mux select
dp_SD  out  1  datapath demux select
dp_AS  out  1  datapath add/sub select
dp_a  out  N  to datapath a
dp_b  out  N  to datapath b
dp_c  out  N  to datapath c
dp_sum  in  N+1  datapath Sum
dp_sub  in  N+1  datapath Sub
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_result  out  N+1  signed final result
rsp_ovf  out  1  sticky overflow flag
rsp_iters  out  CW  iterations actually executed
busy  out  1  high when not in IDLE

Behaviour:
- Reset: all outputs and registers go to 0; state = IDLE. Reset in any state aborts the operation and drops any pending response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch a, b, c, op and eff_cnt = (cmd_cnt == 0 ? 1 : cmd_cnt).
  - Clear ovf and iters; go to EXEC.
- Datapath drive: dp_a/b/c come from the operand registers at all times.
  - dp_AS = op[0], dp_SM = op[1].
  - dp_SD = op[0], so subtraction results are taken from the Sub port.
- EXEC (one cycle per iteration):
  - r = op[0] ? dp_sub : dp_sum. iters increments each cycle.
  - Fit test: r fits in N bits when r[N] == r[N-1].
  - r fits: result <= r, a <= r[N-1:0].
    - If iters+1 == eff_cnt, go to RESP; otherwise stay in EXEC.
  - r does not fit: ovf <= 1, result <= r (full N+1 bits), go to RESP immediately (early termination). See the optional feature for the alternative.
- RESP:
  - rsp_valid = 1. rsp_result, rsp_ovf and rsp_iters stay stable while rsp_ready = 0.
  - rsp_valid && rsp_ready: go to IDLE next cycle. rsp_valid falls that cycle and rsp_* hold their values.
  - No bypass: a new command is not accepted in the same cycle as the response handshake.
- Latency: command accepted at cycle T → rsp_valid asserted at T+1+k, where k = number of iterations executed.
- cmd_valid while busy is ignored (cmd_ready = 0). The issuer holds the command until it is accepted.
- Width rule: all arithmetic is signed. Operand registers are N bits; the result register is N+1 bits.

Optional Feature:
Macro ADDSUB_SAT_EN.
- Defined:
  - An overflowing r is clamped to +(2^(N-1)-1) if r[N] = 0, or -(2^(N-1)) if r[N] = 1.
  - The clamped value is written to both result and a.
  - ovf is set and stays sticky; iteration continues to eff_cnt (no early exit).
- Undefined: early-termination behaviour as above.

Test Plan:
- N=4, a=3, b=2, op=00, cnt=1 → rsp_result = 5, ovf = 0, iters = 1, rsp_valid at T+2; dp_SM = 0, dp_AS = 0.
- a=3, b=2, op=00, cnt=3 → no SAT: result = 9 (5'b01001), ovf = 1, iters = 3. With ADDSUB_SAT_EN: result = 7, ovf = 1, iters = 3.
- a=-8, c=1, op=11 (A-C), cnt=1 → dp_SM = 1, dp_SD = 1, dp_AS = 1; result = -9 (5'b10111), ovf = 1. With SAT: result = -8.
- a=5, c=1, op=11, cnt=0 → treated as 1: result = 4, iters = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP → rsp_* stable and cmd_ready = 0 throughout; second cmd_valid accepted only in the cycle after the response handshake.
- Assert reset for 1 cycle mid-EXEC (a=1, b=1, cnt=7) → next cycle: IDLE, busy = 0, rsp_valid = 0, all outputs 0, cmd_ready = 1.
